// File: rtl/wb_present_csr_pkg.sv
// Shared definitions for the PRESENT Wishbone CSR block: register map helpers,
// CTRL/STATUS bit positions and the launch FSM state type.
package present_csr_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsm_state_e;

    localparam int CTRL_START = 0;
    localparam int CTRL_IE    = 1;
    localparam int CTRL_CLR   = 2;

    localparam int STAT_BUSY  = 0;
    localparam int STAT_DONE  = 1;
    localparam int STAT_TOUT  = 2;
    localparam int STAT_WERR  = 3;

    // The CSR window is 64 bytes, so address bits [31:6] select it.
    localparam int WIN_LSB    = 6;

    function automatic int words_of(input int bits);
        return (bits + 31) / 32;
    endfunction

    function automatic int plain_off(input int kw);
        return kw;
    endfunction

    function automatic int result_off(input int kw, input int dw);
        return kw + dw;
    endfunction

    function automatic int ctrl_off(input int kw, input int dw);
        return kw + 2 * dw;
    endfunction

    function automatic int stat_off(input int kw, input int dw);
        return kw + 2 * dw + 1;
    endfunction

endpackage

// File: rtl/wb_present_csr_if.sv
// Wishbone slave bus bundle between the caravel WB port and the PRESENT CSR block.
interface wb_present_csr_if;

    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );

endinterface

// File: rtl/wb_present_csr_timeout_ctr.sv
// Watchdog for one cipher run: expires during the TIMEOUT_CYCLES-th enabled cycle after a clear.
module timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign expired_o = enable_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && !expired_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wb_present_csr.sv
// Wishbone CSR front-end for the PRESENT core: key/plaintext registers, one-shot launch,
// result capture, sticky status flags with write-1-to-clear, and a level IRQ.
module wb_present_csr
    import present_csr_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS   = 32'h3000_0000,
    parameter int          KEY_BITS       = 80,
    parameter int          BLOCK_BITS     = 64,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    wb_present_csr_if.slave       wb,
    output logic [KEY_BITS-1:0]   key_o,
    output logic [BLOCK_BITS-1:0] block_o,
    output logic                  start_o,
    input  logic                  done_i,
    input  logic [BLOCK_BITS-1:0] result_i,
    output logic                  irq_o
);

    localparam int KEY_WORDS  = words_of(KEY_BITS);
    localparam int DATA_WORDS = words_of(BLOCK_BITS);
    localparam int OFF_PLAIN  = plain_off(KEY_WORDS);
    localparam int OFF_RESULT = result_off(KEY_WORDS, DATA_WORDS);
    localparam int OFF_CTRL   = ctrl_off(KEY_WORDS, DATA_WORDS);
    localparam int OFF_STAT   = stat_off(KEY_WORDS, DATA_WORDS);

    fsm_state_e              state_q, state_d;
    logic                    ack_q, ack_d;
    logic [31:0]             dat_q, dat_d;
    logic [KEY_BITS-1:0]     key_q, key_d;
    logic [BLOCK_BITS-1:0]   plain_q, plain_d;
    logic [BLOCK_BITS-1:0]   result_q, result_d;
    logic                    ie_q, ie_d;
    logic                    done_q, done_d;
    logic                    tout_q, tout_d;
    logic                    werr_q, werr_d;
    logic                    start_q, start_d;

    logic                    valid, acc, wr, rd, busy;
    logic                    ctrl_wr, stat_wr, start_cmd, clr_cmd, kp_wr;
    logic                    done_set, tout_set, tmr_clr, tmr_en, tmr_exp;
    logic [3:0]              word;
    logic [31:0]             rdata;
    logic [KEY_WORDS*32-1:0] key_rd, key_wr;
    logic [DATA_WORDS*32-1:0] plain_rd, plain_wr, result_rd;
    logic                    unused_adr;

    assign word       = wb.wbs_adr_i[5:2];
    assign unused_adr = ^wb.wbs_adr_i[1:0];
    assign valid      = wb.wbs_cyc_i & wb.wbs_stb_i &
                        (wb.wbs_adr_i[31:WIN_LSB] == BASE_ADDRESS[31:WIN_LSB]);
    assign acc        = valid & ~ack_q;
    assign wr         = acc & wb.wbs_we_i;
    assign rd         = acc & ~wb.wbs_we_i;
    assign busy       = (state_q == RUN);
    assign ctrl_wr    = wr & (word == 4'(OFF_CTRL)) & wb.wbs_sel_i[0];
    assign stat_wr    = wr & (word == 4'(OFF_STAT)) & wb.wbs_sel_i[0];
    assign start_cmd  = ctrl_wr & wb.wbs_dat_i[CTRL_START];
    assign clr_cmd    = ctrl_wr & wb.wbs_dat_i[CTRL_CLR];

    // Registers are viewed zero-padded to whole words, so bits past KEY_BITS/BLOCK_BITS read 0.
    always_comb begin
        key_rd                      = '0;
        key_rd[KEY_BITS-1:0]        = key_q;
        plain_rd                    = '0;
        plain_rd[BLOCK_BITS-1:0]    = plain_q;
        result_rd                   = '0;
        result_rd[BLOCK_BITS-1:0]   = result_q;
        key_wr                      = key_rd;
        plain_wr                    = plain_rd;
        kp_wr                       = 1'b0;
        rdata                       = '0;
        for (int w = 0; w < KEY_WORDS; w++) begin
            if (word == 4'(w)) begin
                rdata = key_rd[w*32 +: 32];
                if (wr) begin
                    kp_wr = 1'b1;
                    for (int b = 0; b < 4; b++) begin
                        if (wb.wbs_sel_i[b]) key_wr[w*32+b*8 +: 8] = wb.wbs_dat_i[b*8 +: 8];
                    end
                end
            end
        end
        for (int w = 0; w < DATA_WORDS; w++) begin
            if (word == 4'(OFF_PLAIN + w)) begin
                rdata = plain_rd[w*32 +: 32];
                if (wr) begin
                    kp_wr = 1'b1;
                    for (int b = 0; b < 4; b++) begin
                        if (wb.wbs_sel_i[b]) plain_wr[w*32+b*8 +: 8] = wb.wbs_dat_i[b*8 +: 8];
                    end
                end
            end
            if (word == 4'(OFF_RESULT + w)) rdata = result_rd[w*32 +: 32];
        end
        if (word == 4'(OFF_CTRL)) rdata[CTRL_IE] = ie_q;
        if (word == 4'(OFF_STAT)) begin
            rdata[STAT_BUSY] = busy;
            rdata[STAT_DONE] = done_q;
            rdata[STAT_TOUT] = tout_q;
            rdata[STAT_WERR] = werr_q;
        end
    end

    // Done takes priority over a timer expiry landing on the same cycle.
    always_comb begin
        state_d  = state_q;
        start_d  = 1'b0;
        tmr_clr  = 1'b0;
        tmr_en   = 1'b0;
        done_set = 1'b0;
        tout_set = 1'b0;
        result_d = result_q;
        unique case (state_q)
            IDLE: begin
                if (start_cmd) begin
                    state_d = RUN;
                    start_d = 1'b1;
                    tmr_clr = 1'b1;
                end
            end
            RUN: begin
                tmr_en = 1'b1;
                if (done_i) begin
                    result_d = result_i;
                    done_set = 1'b1;
                    state_d  = IDLE;
                end else if (tmr_exp) begin
                    tout_set = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ack_d   = valid & ~ack_q;
        dat_d   = rd ? rdata : '0;
        key_d   = key_q;
        plain_d = plain_q;
        if (!busy) begin
            if (clr_cmd) begin
                key_d   = '0;
                plain_d = '0;
            end else if (kp_wr) begin
                key_d   = key_wr[KEY_BITS-1:0];
                plain_d = plain_wr[BLOCK_BITS-1:0];
            end
        end
        ie_d   = ctrl_wr ? wb.wbs_dat_i[CTRL_IE] : ie_q;
        done_d = (done_q & ~(stat_wr & wb.wbs_dat_i[STAT_DONE])) | done_set;
        tout_d = (tout_q & ~(stat_wr & wb.wbs_dat_i[STAT_TOUT])) | tout_set;
        werr_d = (werr_q & ~(stat_wr & wb.wbs_dat_i[STAT_WERR])) |
                 (busy & (kp_wr | start_cmd | clr_cmd));
    end

    timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (tmr_clr),
        .enable_i  (tmr_en),
        .expired_o (tmr_exp)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ack_q    <= 1'b0;
            dat_q    <= '0;
            key_q    <= '0;
            plain_q  <= '0;
            result_q <= '0;
            ie_q     <= 1'b0;
            done_q   <= 1'b0;
            tout_q   <= 1'b0;
            werr_q   <= 1'b0;
            start_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            dat_q    <= dat_d;
            key_q    <= key_d;
            plain_q  <= plain_d;
            result_q <= result_d;
            ie_q     <= ie_d;
            done_q   <= done_d;
            tout_q   <= tout_d;
            werr_q   <= werr_d;
            start_q  <= start_d;
        end
    end

    assign wb.wbs_ack_o = ack_q;
    assign wb.wbs_dat_o = dat_q;
    assign key_o        = key_q;
    assign block_o      = plain_q;
    assign start_o      = start_q;
    assign irq_o        = ie_q & (done_q | tout_q);

endmodule

// File: tb/tb_wb_present_csr.sv
// Directed bench for wb_present_csr: register map, byte enables, launch/done,
// write-while-busy, timeout, done/timeout collision, START+CLR and mid-run reset.
module tb_wb_present_csr;

    localparam logic [31:0] BASE   = 32'h3000_0000;
    localparam logic [31:0] A_KEY0 = BASE + 32'h00;
    localparam logic [31:0] A_KEY1 = BASE + 32'h04;
    localparam logic [31:0] A_KEY2 = BASE + 32'h08;
    localparam logic [31:0] A_PL0  = BASE + 32'h0C;
    localparam logic [31:0] A_PL1  = BASE + 32'h10;
    localparam logic [31:0] A_RES0 = BASE + 32'h14;
    localparam logic [31:0] A_RES1 = BASE + 32'h18;
    localparam logic [31:0] A_CTRL = BASE + 32'h1C;
    localparam logic [31:0] A_STAT = BASE + 32'h20;

    logic        clk = 1'b0;
    logic        rst;
    logic [79:0] key_o;
    logic [63:0] block_o;
    logic [63:0] result_i;
    logic        start_o;
    logic        done_i;
    logic        irq_o;

    int          n_checks = 0;
    int          n_fail = 0;
    int          start_pulses = 0;
    int          cyc_cnt = 0;
    int          t0;
    logic        start_at_ack;
    logic        seen;
    logic [31:0] rd;

    wb_present_csr_if bus ();

    wb_present_csr #(
        .BASE_ADDRESS   (BASE),
        .KEY_BITS       (80),
        .BLOCK_BITS     (64),
        .TIMEOUT_CYCLES (255)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wb       (bus),
        .key_o    (key_o),
        .block_o  (block_o),
        .start_o  (start_o),
        .done_i   (done_i),
        .result_i (result_i),
        .irq_o    (irq_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (start_o) start_pulses <= start_pulses + 1;
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wb_read(input logic [31:0] adr, output logic [31:0] data);
        int n = 0;
        @(negedge clk);
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_sel_i = 4'hF;
        bus.wbs_adr_i = adr;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.wbs_ack_o && n < 8);
        check_eq("rd_ack_lat", 128'(n), 128'(1));
        data = bus.wbs_dat_o;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] data, input logic [3:0] sel);
        int n = 0;
        @(negedge clk);
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = 1'b1;
        bus.wbs_sel_i = sel;
        bus.wbs_adr_i = adr;
        bus.wbs_dat_i = data;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.wbs_ack_o && n < 8);
        check_eq("wr_ack_lat", 128'(n), 128'(1));
        start_at_ack  = start_o;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        logic [31:0] d;
        wb_read(adr, d);
        check_eq(tag, 128'(d), 128'(exp));
    endtask

    initial begin
        rst           = 1'b1;
        done_i        = 1'b0;
        result_i      = '0;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_sel_i = 4'h0;
        bus.wbs_adr_i = '0;
        bus.wbs_dat_i = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_eq("rst_irq", 128'(irq_o), 128'(0));
        check_eq("rst_start", 128'(start_o), 128'(0));

        for (int i = 0; i <= 8; i++) begin
            wb_read(BASE + 32'(i * 4), rd);
            check_eq("rst_rd", 128'(rd), 128'(0));
            @(negedge clk);
            check_eq("ack_one_cycle", 128'(bus.wbs_ack_o), 128'(0));
        end

        // key words, bits above bit 79 dropped, byte enables
        wb_write(A_KEY0, 32'h0123_4567, 4'hF);
        wb_write(A_KEY1, 32'h89AB_CDEF, 4'hF);
        wb_write(A_KEY2, 32'h1234_5678, 4'hF);
        rd_chk("key2_trunc", A_KEY2, 32'h0000_5678);
        wb_write(A_KEY2, 32'hFFFF_FFFF, 4'b0011);
        check_eq("key_o", 128'(key_o), 128'(80'hFFFF_89AB_CDEF_0123_4567));
        rd_chk("key2_rd", A_KEY2, 32'h0000_FFFF);

        wb_write(A_PL0, 32'h1122_3344, 4'hF);
        wb_write(A_PL1, 32'h5566_7788, 4'hF);
        wb_write(A_PL1, 32'hAABB_CCDD, 4'b1000);
        check_eq("block_o", 128'(block_o), 128'(64'hAA66_7788_1122_3344));

        rd_chk("unmapped", BASE + 32'h24, 32'h0);
        wb_write(A_RES0, 32'hFFFF_FFFF, 4'hF);
        rd_chk("res_ro", A_RES0, 32'h0);

        @(negedge clk);
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_adr_i = BASE + 32'h40;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen |= bus.wbs_ack_o;
        end
        check_eq("oow_noack", 128'(seen), 128'(0));
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;

        // launch with IE; core answers in the 31st busy cycle
        wb_write(A_CTRL, 32'h3, 4'hF);
        check_eq("start_pulse", 128'(start_at_ack), 128'(1));
        @(negedge clk);
        check_eq("start_one_cycle", 128'(start_o), 128'(0));
        rd_chk("busy_early", A_STAT, 32'h1);
        repeat (27) @(negedge clk);
        done_i        = 1'b1;
        result_i      = 64'hDEAD_BEEF_CAFE_F00D;
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_adr_i = A_STAT;
        @(negedge clk);
        done_i = 1'b0;
        check_eq("busy_c31_ack", 128'(bus.wbs_ack_o), 128'(1));
        check_eq("busy_c31", 128'(bus.wbs_dat_o), 128'(32'h1));
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        check_eq("irq_done", 128'(irq_o), 128'(1));
        rd_chk("stat_done", A_STAT, 32'h2);
        rd_chk("res0", A_RES0, 32'hCAFE_F00D);
        rd_chk("res1", A_RES1, 32'hDEAD_BEEF);
        check_eq("pulses_1", 128'(start_pulses), 128'(1));

        @(negedge clk);
        done_i   = 1'b1;
        result_i = 64'h1111_1111_2222_2222;
        @(negedge clk);
        done_i = 1'b0;
        rd_chk("idle_done_ign", A_RES0, 32'hCAFE_F00D);

        wb_write(A_STAT, 32'h2, 4'h1);
        check_eq("irq_w1c", 128'(irq_o), 128'(0));
        rd_chk("stat_clr", A_STAT, 32'h0);

        // writes while busy, then timeout after 255 busy cycles
        wb_write(A_CTRL, 32'h3, 4'hF);
        t0 = cyc_cnt;
        wb_write(A_PL0, 32'h1, 4'hF);
        wb_write(A_CTRL, 32'h3, 4'hF);
        wb_write(A_CTRL, 32'h6, 4'hF);
        check_eq("pl_kept", 128'(block_o), 128'(64'hAA66_7788_1122_3344));
        check_eq("key_kept", 128'(key_o), 128'(80'hFFFF_89AB_CDEF_0123_4567));
        while (cyc_cnt < t0 + 254) @(negedge clk);
        check_eq("irq_pre_tout", 128'(irq_o), 128'(0));
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_adr_i = A_STAT;
        @(negedge clk);
        check_eq("busy_c255", 128'(bus.wbs_dat_o), 128'(32'h9));
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        check_eq("irq_tout", 128'(irq_o), 128'(1));
        rd_chk("stat_tout", A_STAT, 32'hC);
        rd_chk("res_kept", A_RES0, 32'hCAFE_F00D);
        rd_chk("pl0_kept", A_PL0, 32'h1122_3344);
        check_eq("pulses_2", 128'(start_pulses), 128'(2));
        wb_write(A_STAT, 32'h4, 4'h1);
        rd_chk("tout_w1c", A_STAT, 32'h8);
        check_eq("irq_tout_clr", 128'(irq_o), 128'(0));
        wb_write(A_STAT, 32'h8, 4'h1);
        rd_chk("werr_w1c", A_STAT, 32'h0);

        // done_i on the expiry cycle: done wins
        wb_write(A_CTRL, 32'h3, 4'hF);
        t0 = cyc_cnt;
        while (cyc_cnt < t0 + 254) @(negedge clk);
        done_i   = 1'b1;
        result_i = 64'h0123_4567_89AB_CDEF;
        @(negedge clk);
        done_i = 1'b0;
        rd_chk("collide_stat", A_STAT, 32'h2);
        rd_chk("collide_res0", A_RES0, 32'h89AB_CDEF);
        rd_chk("collide_res1", A_RES1, 32'h0123_4567);

        // START with CLR launches and clears, then reset mid-run
        wb_write(A_CTRL, 32'h7, 4'hF);
        check_eq("startclr_pulse", 128'(start_at_ack), 128'(1));
        check_eq("clr_key", 128'(key_o), 128'(0));
        check_eq("clr_block", 128'(block_o), 128'(0));
        repeat (3) @(negedge clk);
        check_eq("pulses_4", 128'(start_pulses), 128'(4));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("rst_run_irq", 128'(irq_o), 128'(0));
        done_i   = 1'b1;
        result_i = '1;
        @(negedge clk);
        done_i = 1'b0;
        check_eq("rst_done_irq", 128'(irq_o), 128'(0));
        for (int i = 0; i <= 8; i++) begin
            rd_chk("rst_run_rd", BASE + 32'(i * 4), 32'h0);
        end
        check_eq("rst_run_start", 128'(start_o), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
